// File: rtl/sram_ctrl_s00_axil_slave.sv
// AXI4-Lite slave exposing four 32-bit control registers to the SRAM controller core.
// Valid/ready rule: a beat transfers on a rising edge where valid and ready are both 1; once raised, valid holds until that edge.
module sram_ctrl_s00_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg3,
    output logic [3:0]                      reg_wr_pulse
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = C_S_AXI_DATA_WIDTH / 8;

    logic          ready_ok;
    logic          aw_held;
    logic          w_held;
    logic [1:0]    aw_sel_q;
    logic [DW-1:0] w_data_q;
    logic [NB-1:0] w_strb_q;
    logic [DW-1:0] regs [4];

    logic          aw_hs, w_hs, ar_hs, commit;
    logic [1:0]    commit_sel;
    logic [DW-1:0] commit_data;
    logic [NB-1:0] commit_strb;
    logic          unused_inputs;

    assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                             s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign s00_axi_awready = ready_ok & ~aw_held & ~s00_axi_bvalid;
    assign s00_axi_wready  = ready_ok & ~w_held & ~s00_axi_bvalid;
    assign s00_axi_arready = ready_ok & ~s00_axi_rvalid;

    assign aw_hs  = s00_axi_awvalid & s00_axi_awready;
    assign w_hs   = s00_axi_wvalid & s00_axi_wready;
    assign ar_hs  = s00_axi_arvalid & s00_axi_arready;
    assign commit = (aw_held | aw_hs) & (w_held | w_hs);

    // A held beat takes priority over the live bus, since its ready is low anyway.
    always_comb begin
        commit_sel  = s00_axi_awaddr[3:2];
        commit_data = s00_axi_wdata;
        commit_strb = s00_axi_wstrb;
        if (aw_held) commit_sel = aw_sel_q;
        if (w_held) begin
            commit_data = w_data_q;
            commit_strb = w_strb_q;
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            ready_ok       <= 1'b0;
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            aw_sel_q       <= '0;
            w_data_q       <= '0;
            w_strb_q       <= '0;
            s00_axi_bvalid <= 1'b0;
            s00_axi_bresp  <= 2'b00;
            reg_wr_pulse   <= 4'b0000;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            ready_ok     <= 1'b1;
            reg_wr_pulse <= 4'b0000;
            if (commit) begin
                for (int i = 0; i < 4; i++) begin
                    if (commit_sel == 2'(i)) begin
                        for (int b = 0; b < NB; b++) begin
                            if (commit_strb[b]) regs[i][8*b +: 8] <= commit_data[8*b +: 8];
                        end
                    end
                end
                reg_wr_pulse   <= 4'b0001 << commit_sel;
                s00_axi_bvalid <= 1'b1;
                s00_axi_bresp  <= 2'b00;
                aw_held        <= 1'b0;
                w_held         <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_held  <= 1'b1;
                    aw_sel_q <= s00_axi_awaddr[3:2];
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= s00_axi_wdata;
                    w_strb_q <= s00_axi_wstrb;
                end
                if (s00_axi_bvalid && s00_axi_bready) s00_axi_bvalid <= 1'b0;
            end
        end
    end

    // Read path samples the registers before any same-edge commit lands.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            s00_axi_rvalid <= 1'b0;
            s00_axi_rdata  <= '0;
            s00_axi_rresp  <= 2'b00;
        end else if (ar_hs) begin
            s00_axi_rvalid <= 1'b1;
            s00_axi_rdata  <= regs[s00_axi_araddr[3:2]];
            s00_axi_rresp  <= 2'b00;
        end else if (s00_axi_rvalid && s00_axi_rready) begin
            s00_axi_rvalid <= 1'b0;
        end
    end

    assign slv_reg0 = regs[0];
    assign slv_reg1 = regs[1];
    assign slv_reg2 = regs[2];
    assign slv_reg3 = regs[3];
endmodule
